countdown_sequencer: RTL and testbench



---
 rtl/countdown_sequencer_if.sv | 24 ++
 rtl/countdown_sequencer.sv | 166 ++++++++++++++++
 tb/tb_countdown_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_sequencer_if.sv
// Controller <-> sequencer bundle for the egg timer: load/run/flash enables in,
// time value, time-flat status, tick pulse and display enable out.
interface countdown_sequencer_if;
    logic       swSecEn;
    logic       swMinEn;
    logic       decEn;
    logic       flashEn;
    logic [6:0] sw;
    logic [5:0] secs;
    logic [6:0] mins;
    logic       isTimeFlat;
    logic       tick;
    logic       displayOn;

    modport master (
        output swSecEn, swMinEn, decEn, flashEn, sw,
        input  secs, mins, isTimeFlat, tick, displayOn
    );

    modport slave (
        input  swSecEn, swMinEn, decEn, flashEn, sw,
        output secs, mins, isTimeFlat, tick, displayOn
    );
endinterface

// File: rtl/countdown_sequencer.sv
// Egg-timer datapath: loads mm:ss from switches, counts down on a prescaled tick,
// flags 00:00 and blinks the display. Optional OVERTIME_EN counts up after 00:00.
module countdown_sequencer #(
    parameter int TICK_DIV  = 50000000,
    parameter int FLASH_DIV = 12500000
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_sequencer_if.slave  bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLAT} state_t;

    state_t         state_reg,  state_next;
    logic [5:0]     secs_reg,   secs_next;
    logic [6:0]     mins_reg,   mins_next;
    logic           flat_reg,   flat_next;
    logic           tick_reg,   tick_next;
    logic [PW-1:0]  presc_reg,  presc_next;
    logic [FW-1:0]  flash_reg;
    logic           disp_reg;

    logic           is_zero;
    logic           presc_wrap;
    logic [5:0]     dec_secs;
    logic [6:0]     dec_mins;

    function automatic logic [5:0] sat_secs(input logic [6:0] v);
        return (v > 7'd59) ? 6'd59 : v[5:0];
    endfunction

    function automatic logic [6:0] sat_mins(input logic [6:0] v);
        return (v > 7'd99) ? 7'd99 : v;
    endfunction

    assign is_zero    = (secs_reg == 6'd0) && (mins_reg == 7'd0);
    assign presc_wrap = (presc_reg == PRESC_LAST);

    always_comb begin
        dec_secs = secs_reg;
        dec_mins = mins_reg;
        if (secs_reg != 6'd0) begin
            dec_secs = secs_reg - 6'd1;
        end else if (mins_reg != 7'd0) begin
            dec_mins = mins_reg - 7'd1;
            dec_secs = 6'd59;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            secs_reg  <= '0;
            mins_reg  <= '0;
            flat_reg  <= 1'b0;
            tick_reg  <= 1'b0;
            presc_reg <= '0;
        end else begin
            state_reg <= state_next;
            secs_reg  <= secs_next;
            mins_reg  <= mins_next;
            flat_reg  <= flat_next;
            tick_reg  <= tick_next;
            presc_reg <= presc_next;
        end
    end

    // Prescaler defaults to 0 so every pause, load or state change restarts a full tick period.
    always_comb begin
        state_next = state_reg;
        secs_next  = secs_reg;
        mins_next  = mins_reg;
        flat_next  = flat_reg;
        tick_next  = 1'b0;
        presc_next = '0;

        case (state_reg)
            IDLE: begin
                if (bus.decEn) begin
                    if (is_zero) begin
                        state_next = FLAT;
                        flat_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    if (bus.swSecEn) secs_next = sat_secs(bus.sw);
                    if (bus.swMinEn) mins_next = sat_mins(bus.sw);
                end
            end

            RUN: begin
                if (!bus.decEn) begin
                    state_next = IDLE;
                end else if (presc_wrap) begin
                    tick_next = 1'b1;
                    secs_next = dec_secs;
                    mins_next = dec_mins;
                    if ((dec_secs == 6'd0) && (dec_mins == 7'd0)) begin
                        state_next = FLAT;
                        flat_next  = 1'b1;
                    end
                end else begin
                    presc_next = presc_reg + PW'(1);
                end
            end

            FLAT: begin
                if (bus.decEn) begin
`ifdef OVERTIME_EN
                    if (presc_wrap) begin
                        tick_next = 1'b1;
                        if (!((secs_reg == 6'd59) && (mins_reg == 7'd99))) begin
                            if (secs_reg == 6'd59) begin
                                secs_next = 6'd0;
                                mins_next = mins_reg + 7'd1;
                            end else begin
                                secs_next = secs_reg + 6'd1;
                            end
                        end
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
`endif
                end else if (bus.swSecEn || bus.swMinEn) begin
                    // A load out of FLAT starts from 00:00 so no overtime leaks into the new value.
                    state_next = IDLE;
                    flat_next  = 1'b0;
                    secs_next  = bus.swSecEn ? sat_secs(bus.sw) : 6'd0;
                    mins_next  = bus.swMinEn ? sat_mins(bus.sw) : 7'd0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_reg <= '0;
            disp_reg  <= 1'b1;
        end else if (!bus.flashEn) begin
            flash_reg <= '0;
            disp_reg  <= 1'b1;
        end else if (flash_reg == FLASH_LAST) begin
            flash_reg <= '0;
            disp_reg  <= ~disp_reg;
        end else begin
            flash_reg <= flash_reg + FW'(1);
        end
    end

    assign bus.secs       = secs_reg;
    assign bus.mins       = mins_reg;
    assign bus.isTimeFlat = flat_reg;
    assign bus.tick       = tick_reg;
    assign bus.displayOn  = disp_reg;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed table-driven bench for countdown_sequencer (TICK_DIV=4, FLASH_DIV=2),
// plus hand sequences for flash, async reset and the FLAT/overtime behaviour.
module tb_countdown_sequencer;

    logic clk;
    logic reset;

    countdown_sequencer_if bus ();

    countdown_sequencer #(
        .TICK_DIV  (4),
        .FLASH_DIV (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       se;
        logic       me;
        logic       de;
        logic [6:0] sw;
        int         secs;
        int         mins;
        int         flat;
        int         tick;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t mk(input int se, input int me, input int de, input int sw,
                                input int s, input int m, input int f, input int t);
        vec_t v;
        v.se   = (se != 0);
        v.me   = (me != 0);
        v.de   = (de != 0);
        v.sw   = 7'(sw);
        v.secs = s;
        v.mins = m;
        v.flat = f;
        v.tick = t;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic se, input logic me, input logic de, input logic [6:0] sw);
        bus.swSecEn = se;
        bus.swMinEn = me;
        bus.decEn   = de;
        bus.sw      = sw;
    endtask

    initial begin
        int exp_disp[6];
        int ticks;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.flashEn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 7'd0);

        // Load saturation, both-enable load, countdown to flat
        vecs.push_back(mk(1,0,0,75,  59,0,0,0));
        vecs.push_back(mk(0,1,0,3,   59,3,0,0));
        vecs.push_back(mk(0,0,0,0,   59,3,0,0));
        vecs.push_back(mk(0,1,0,120, 59,99,0,0));
        vecs.push_back(mk(1,1,0,0,   0,0,0,0));
        vecs.push_back(mk(1,0,0,2,   2,0,0,0));
        vecs.push_back(mk(0,0,1,0,   2,0,0,0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,1,0, 2,0,0,0));
        vecs.push_back(mk(0,0,1,0,   1,0,0,1));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,1,0, 1,0,0,0));
        vecs.push_back(mk(0,0,1,0,   0,0,1,1));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,1,0, 0,0,1,0));
        // Minutes borrow, pause, resume with full period
        vecs.push_back(mk(0,1,0,1,   0,1,0,0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(0,0,1,0, 0,1,0,0));
        vecs.push_back(mk(0,0,1,0,   59,0,0,1));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,0,0, 59,0,0,0));
        vecs.push_back(mk(0,0,1,0,   59,0,0,0));
        vecs.push_back(mk(1,0,1,10,  59,0,0,0));
        vecs.push_back(mk(0,0,1,0,   59,0,0,0));
        vecs.push_back(mk(0,0,1,0,   59,0,0,0));
        vecs.push_back(mk(0,0,1,0,   58,0,0,1));
        // Load ignored on the RUN->IDLE cycle, accepted in IDLE; load out of FLAT
        vecs.push_back(mk(1,0,0,10,  58,0,0,0));
        vecs.push_back(mk(1,0,0,10,  10,0,0,0));
        vecs.push_back(mk(1,1,0,0,   0,0,0,0));
        vecs.push_back(mk(0,0,1,0,   0,0,1,0));
        vecs.push_back(mk(1,0,1,5,   0,0,1,0));
        vecs.push_back(mk(1,0,0,5,   5,0,0,0));
        vecs.push_back(mk(0,0,0,0,   5,0,0,0));

        #12;
        chk("reset secs", int'(bus.secs), 0);
        chk("reset mins", int'(bus.mins), 0);
        chk("reset flat", int'(bus.isTimeFlat), 0);
        chk("reset tick", int'(bus.tick), 0);
        chk("reset displayOn", int'(bus.displayOn), 1);
        $display("reset: secs=%0d mins=%0d flat=%0b disp=%0b", bus.secs, bus.mins, bus.isTimeFlat, bus.displayOn);
        #1 reset = 1'b0;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].se, vecs[i].me, vecs[i].de, vecs[i].sw);
            step();
            $display("row %0d: se=%0b me=%0b de=%0b sw=%0d -> %0d:%0d flat=%0b tick=%0b",
                     i, vecs[i].se, vecs[i].me, vecs[i].de, vecs[i].sw,
                     bus.mins, bus.secs, bus.isTimeFlat, bus.tick);
            chk($sformatf("row%0d secs", i), int'(bus.secs), vecs[i].secs);
            chk($sformatf("row%0d mins", i), int'(bus.mins), vecs[i].mins);
            chk($sformatf("row%0d flat", i), int'(bus.isTimeFlat), vecs[i].flat);
            chk($sformatf("row%0d tick", i), int'(bus.tick), vecs[i].tick);
            chk($sformatf("row%0d displayOn", i), int'(bus.displayOn), 1);
        end

        // Asynchronous reset in the middle of a 01:30 countdown
        drive(1'b1, 1'b0, 1'b0, 7'd30);
        step();
        drive(1'b0, 1'b1, 1'b0, 7'd1);
        step();
        drive(1'b0, 1'b0, 1'b1, 7'd0);
        for (int k = 0; k < 3; k++) step();
        chk("prerst secs", int'(bus.secs), 30);
        chk("prerst mins", int'(bus.mins), 1);
        #3 reset = 1'b1;
        #1;
        $display("async reset: secs=%0d mins=%0d flat=%0b tick=%0b disp=%0b",
                 bus.secs, bus.mins, bus.isTimeFlat, bus.tick, bus.displayOn);
        chk("arst secs", int'(bus.secs), 0);
        chk("arst mins", int'(bus.mins), 0);
        chk("arst flat", int'(bus.isTimeFlat), 0);
        chk("arst displayOn", int'(bus.displayOn), 1);
        #3 reset = 1'b0;
        step();
        $display("post reset: secs=%0d flat=%0b tick=%0b", bus.secs, bus.isTimeFlat, bus.tick);
        chk("postrst tick", int'(bus.tick), 0);
        chk("postrst flat", int'(bus.isTimeFlat), 1);

        // FLAT with decEn held for 8 cycles
        ticks = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.tick) ticks++;
        end
        $display("flat hold: secs=%0d mins=%0d flat=%0b ticks=%0d", bus.secs, bus.mins, bus.isTimeFlat, ticks);
`ifdef OVERTIME_EN
        chk("overtime secs", int'(bus.secs), 2);
        chk("overtime ticks", ticks, 2);
`else
        chk("flat hold secs", int'(bus.secs), 0);
        chk("flat hold ticks", ticks, 0);
`endif
        chk("flat hold mins", int'(bus.mins), 0);
        chk("flat hold flag", int'(bus.isTimeFlat), 1);
        drive(1'b0, 1'b0, 1'b0, 7'd0);

        // Flash: 1 before the first edge, then toggles every FLASH_DIV cycles
        exp_disp = '{1, 0, 0, 1, 1, 0};
        bus.flashEn = 1'b1;
        #1;
        chk("flash start", int'(bus.displayOn), 1);
        for (int k = 0; k < 6; k++) begin
            step();
            $display("flash cycle %0d: displayOn=%0b", k + 1, bus.displayOn);
            chk($sformatf("flash%0d", k + 1), int'(bus.displayOn), exp_disp[k]);
        end
        bus.flashEn = 1'b0;
        step();
        $display("flash off: displayOn=%0b", bus.displayOn);
        chk("flash off", int'(bus.displayOn), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
